// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared core-wide constants and types: instruction width, default PC width,
// reset fetch address, PC / instruction typedefs and a saturating 32-bit
// increment helper used by the optional fetch statistics counters.
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int INST_W = 16;
    localparam int PC_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's instruction-memory bus and its IF/ID boundary.
//   imem_addr / imem_rdata : synchronous instruction memory (1-cycle latency)
//   stall_id, redirect, redirect_pc, is_halt_id : control from ID / branch unit
//   inst_id, pc_id, flushed, halted            : instruction presented to ID
// Modports: master = fetch stage, slave = memory plus decoder/branch side.
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int PC_W = core_pkg::PC_W
);
    logic [PC_W-1:0]              imem_addr;
    logic [core_pkg::INST_W-1:0]  imem_rdata;
    logic                         stall_id;
    logic                         redirect;
    logic [PC_W-1:0]              redirect_pc;
    logic                         is_halt_id;
    logic [core_pkg::INST_W-1:0]  inst_id;
    logic [PC_W-1:0]              pc_id;
    logic                         flushed;
    logic                         halted;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall_id,
        input  redirect,
        input  redirect_pc,
        input  is_halt_id,
        output inst_id,
        output pc_id,
        output flushed,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall_id,
        output redirect,
        output redirect_pc,
        output is_halt_id,
        input  inst_id,
        input  pc_id,
        input  flushed,
        input  halted
    );
endinterface

// File: rtl/fetch_stage_inst_hold_reg.sv
// ---------------------------------------------------------------------------
// inst_hold_reg
// One-entry hold register for the IF/ID boundary. While ID stalls, the
// memory output moves on to the next address, so the instruction sitting in
// ID is captured on the first stall cycle and replayed from here.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   imem_rdata  : instruction memory read data
//   stall       : ID is stalling this cycle (capture on first cycle)
//   clear       : drop any held instruction (normal advance or redirect)
//   inst        : instruction to present to ID
//   valid       : held instruction is being presented
// With neither stall nor clear asserted the register simply keeps its state.
// ---------------------------------------------------------------------------
module inst_hold_reg
    import core_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  inst_t imem_rdata,
    input  logic  stall,
    input  logic  clear,
    output inst_t inst,
    output logic  valid
);

    inst_t hold_inst_r;
    logic  hold_v_r;

    // Capture on the first stall cycle, keep through later stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v_r    <= 1'b0;
            hold_inst_r <= {INST_W{1'b0}};
        end else if (clear) begin
            hold_v_r    <= 1'b0;
            hold_inst_r <= hold_inst_r;
        end else if (stall && !hold_v_r) begin
            hold_v_r    <= 1'b1;
            hold_inst_r <= imem_rdata;
        end else begin
            hold_v_r    <= hold_v_r;
            hold_inst_r <= hold_inst_r;
        end
    end

    assign inst  = hold_v_r ? hold_inst_r : imem_rdata;
    assign valid = hold_v_r;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch and IF/ID boundary. Owns the PC, addresses the
// synchronous instruction memory and presents one instruction per cycle to
// the decoder with its PC and a bubble qualifier (flushed).
// Per-cycle priority: reset > redirect > halt > stall > normal advance.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_stage_if.master (memory bus + IF/ID signals)
//   perf_fetched, perf_flushed : saturating statistics, present only when
//                                the FETCH_PERF_EN macro is defined
// ---------------------------------------------------------------------------
module fetch_stage
    import core_pkg::*;
#(
    parameter int              PC_W     = core_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(core_pkg::RESET_PC)
) (
    input  logic         clk,
    input  logic         reset,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_flushed
`endif
);

    logic [PC_W-1:0] pc_f_r;
    logic [PC_W-1:0] pc_d_r;
    logic            flush_q_r;
    logic            halt_q_r;

    logic            redirect_s;
    logic            halt_go_s;
    logic            stall_s;
    logic            normal_s;
    logic            hold_clear_s;
    logic            hold_valid_s;
    logic            flushed_s;

    // Decode this cycle's action; once halted every input is ignored.
    always_comb begin
        redirect_s   = 1'b0;
        halt_go_s    = 1'b0;
        stall_s      = 1'b0;
        normal_s     = 1'b0;
        if (halt_q_r) begin
            redirect_s = 1'b0;
        end else if (bus.redirect) begin
            redirect_s = 1'b1;
        end else if (bus.is_halt_id && !flush_q_r) begin
            // redirect and halt_q are already excluded, so flushed == flush_q
            halt_go_s = 1'b1;
        end else if (bus.stall_id) begin
            stall_s = 1'b1;
        end else begin
            normal_s = 1'b1;
        end
        hold_clear_s = redirect_s | normal_s;
    end

    // PC, bubble and halt state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_r    <= RESET_PC;
            pc_d_r    <= {PC_W{1'b0}};
            flush_q_r <= 1'b1;
            halt_q_r  <= 1'b0;
        end else if (redirect_s) begin
            // Next cycle's memory data still belongs to the old path.
            pc_f_r    <= bus.redirect_pc;
            pc_d_r    <= bus.redirect_pc;
            flush_q_r <= 1'b1;
            halt_q_r  <= halt_q_r;
        end else if (halt_go_s) begin
            pc_f_r    <= pc_f_r;
            pc_d_r    <= pc_d_r;
            flush_q_r <= flush_q_r;
            halt_q_r  <= 1'b1;
        end else if (normal_s) begin
            pc_f_r    <= pc_f_r + {{(PC_W-1){1'b0}}, 1'b1};
            pc_d_r    <= pc_f_r;
            flush_q_r <= 1'b0;
            halt_q_r  <= halt_q_r;
        end else begin
            // stall or halted: everything freezes
            pc_f_r    <= pc_f_r;
            pc_d_r    <= pc_d_r;
            flush_q_r <= flush_q_r;
            halt_q_r  <= halt_q_r;
        end
    end

    inst_hold_reg u_hold (
        .clk        (clk),
        .reset      (reset),
        .imem_rdata (bus.imem_rdata),
        .stall      (stall_s),
        .clear      (hold_clear_s),
        .inst       (bus.inst_id),
        .valid      (hold_valid_s)
    );

    // The redirect term is combinational so the instruction in ID during a
    // redirect cycle is squashed.
    assign flushed_s     = flush_q_r | bus.redirect | halt_q_r;
    assign bus.imem_addr = pc_f_r;
    assign bus.pc_id     = pc_d_r;
    assign bus.flushed   = flushed_s;
    assign bus.halted    = halt_q_r;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_flushed_r;

    // Saturating counts of delivered instructions and of bubble cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_r <= 32'd0;
            perf_flushed_r <= 32'd0;
        end else begin
            if (!flushed_s && !bus.stall_id) begin
                perf_fetched_r <= sat_inc32(perf_fetched_r);
            end else begin
                perf_fetched_r <= perf_fetched_r;
            end
            if (flushed_s && !halt_q_r) begin
                perf_flushed_r <= sat_inc32(perf_flushed_r);
            end else begin
                perf_flushed_r <= perf_flushed_r;
            end
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_flushed = perf_flushed_r;
`endif

    // Held-entry status is not needed by the control path.
    logic unused_s;
    assign unused_s = hold_valid_s;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage: reset, free run, stall, redirect,
// redirect+stall, halt, reset out of halt and (with FETCH_PERF_EN) the
// statistics counters. mem[i] = 16'hA000 | i except 8101/8202/8303 at 0..2.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    fetch_stage_if #(.PC_W(16)) bus ();

    // Synchronous instruction memory model, one cycle read latency.
    always_ff @(posedge clk) begin
        bus.imem_rdata <= mem[bus.imem_addr[7:0]];
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    fetch_stage #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.stall_id = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.is_halt_id = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp %h", bus.imem_addr, 16'h0000); end
        checks++; if (bus.pc_id !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp %h", bus.pc_id, 16'h0000); end
        checks++; if (bus.flushed !== 1'b1) begin errors++; $display("FAIL reset_flushed got %b exp 1", bus.flushed); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", bus.halted); end
    endtask

    task automatic test_free_run();
        logic [15:0] exp_inst [1:2];
        exp_inst[1] = 16'h8101;
        exp_inst[2] = 16'h8202;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++; if (bus.imem_addr !== 16'(c)) begin errors++; $display("FAIL run_addr c%0d got %h exp %h", c, bus.imem_addr, 16'(c)); end
            checks++; if (bus.inst_id !== exp_inst[c]) begin errors++; $display("FAIL run_inst c%0d got %h exp %h", c, bus.inst_id, exp_inst[c]); end
            checks++; if (bus.pc_id !== 16'(c - 1)) begin errors++; $display("FAIL run_pc c%0d got %h exp %h", c, bus.pc_id, 16'(c - 1)); end
            checks++; if (bus.flushed !== 1'b0) begin errors++; $display("FAIL run_flushed c%0d got %b exp 0", c, bus.flushed); end
        end
    endtask

    task automatic test_stall();
        bus.stall_id = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) bus.stall_id = 1'b0;
            checks++; if (bus.inst_id !== 16'h8202) begin errors++; $display("FAIL stall_inst k%0d got %h exp 8202", k, bus.inst_id); end
            checks++; if (bus.pc_id !== 16'h0001) begin errors++; $display("FAIL stall_pc k%0d got %h exp 0001", k, bus.pc_id); end
            checks++; if (bus.imem_addr !== 16'h0002) begin errors++; $display("FAIL stall_addr k%0d got %h exp 0002", k, bus.imem_addr); end
        end
        tick();
        checks++; if (bus.inst_id !== 16'h8303) begin errors++; $display("FAIL release_inst got %h exp 8303", bus.inst_id); end
        checks++; if (bus.pc_id !== 16'h0002) begin errors++; $display("FAIL release_pc got %h exp 0002", bus.pc_id); end
        checks++; if (bus.imem_addr !== 16'h0003) begin errors++; $display("FAIL release_addr got %h exp 0003", bus.imem_addr); end
    endtask

    task automatic test_redirect();
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0040;
        #1;
        checks++; if (bus.flushed !== 1'b1) begin errors++; $display("FAIL redir_flush0 got %b exp 1", bus.flushed); end
        tick();
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.flushed !== 1'b1) begin errors++; $display("FAIL redir_flush1 got %b exp 1", bus.flushed); end
        checks++; if (bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL redir_addr got %h exp 0040", bus.imem_addr); end
        tick();
        checks++; if (bus.flushed !== 1'b0) begin errors++; $display("FAIL redir_flush2 got %b exp 0", bus.flushed); end
        checks++; if (bus.inst_id !== 16'hA040) begin errors++; $display("FAIL redir_inst got %h exp A040", bus.inst_id); end
        checks++; if (bus.pc_id !== 16'h0040) begin errors++; $display("FAIL redir_pc got %h exp 0040", bus.pc_id); end
        checks++; if (bus.imem_addr !== 16'h0041) begin errors++; $display("FAIL redir_next_addr got %h exp 0041", bus.imem_addr); end
    endtask

    task automatic test_redirect_stall();
        // Load the hold register first, then redirect while still stalling.
        bus.stall_id = 1'b1;
        tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0040;
        #1;
        checks++; if (bus.flushed !== 1'b1) begin errors++; $display("FAIL rs_flush0 got %b exp 1", bus.flushed); end
        tick();
        bus.redirect = 1'b0;
        bus.stall_id = 1'b0;
        #1;
        checks++; if (bus.flushed !== 1'b1) begin errors++; $display("FAIL rs_flush1 got %b exp 1", bus.flushed); end
        checks++; if (bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL rs_addr got %h exp 0040", bus.imem_addr); end
        checks++; if (bus.inst_id !== 16'hA041) begin errors++; $display("FAIL rs_hold_cleared got %h exp A041", bus.inst_id); end
        tick();
        checks++; if (bus.inst_id !== 16'hA040) begin errors++; $display("FAIL rs_inst got %h exp A040", bus.inst_id); end
        checks++; if (bus.pc_id !== 16'h0040) begin errors++; $display("FAIL rs_pc got %h exp 0040", bus.pc_id); end
        checks++; if (bus.flushed !== 1'b0) begin errors++; $display("FAIL rs_flush2 got %b exp 0", bus.flushed); end
    endtask

    task automatic test_halt();
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0005;
        tick();
        bus.redirect = 1'b0;
        tick();
        checks++; if (bus.pc_id !== 16'h0005) begin errors++; $display("FAIL halt_pre_pc got %h exp 0005", bus.pc_id); end
        checks++; if (bus.inst_id !== 16'hA005) begin errors++; $display("FAIL halt_pre_inst got %h exp A005", bus.inst_id); end
        bus.is_halt_id = 1'b1;
        #1;
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b exp 0", bus.halted); end
        tick();
        bus.is_halt_id = 1'b0;
        #1;
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_set got %b exp 1", bus.halted); end
        checks++; if (bus.flushed !== 1'b1) begin errors++; $display("FAIL halt_flushed got %b exp 1", bus.flushed); end
        checks++; if (bus.imem_addr !== 16'h0006) begin errors++; $display("FAIL halt_addr got %h exp 0006", bus.imem_addr); end
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0010;
        bus.stall_id = 1'b1;
        tick();
        bus.redirect = 1'b0;
        bus.stall_id = 1'b0;
        tick();
        checks++; if (bus.imem_addr !== 16'h0006) begin errors++; $display("FAIL halt_frozen_addr got %h exp 0006", bus.imem_addr); end
        checks++; if (bus.pc_id !== 16'h0005) begin errors++; $display("FAIL halt_frozen_pc got %h exp 0005", bus.pc_id); end
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b exp 1", bus.halted); end
        checks++; if (bus.flushed !== 1'b1) begin errors++; $display("FAIL halt_flush_sticky got %b exp 1", bus.flushed); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL unhalt_addr got %h exp 0000", bus.imem_addr); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL unhalt_halted got %b exp 0", bus.halted); end
        checks++; if (bus.flushed !== 1'b1) begin errors++; $display("FAIL unhalt_flushed got %b exp 1", bus.flushed); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        // Reset bubble, 5 instructions, redirect (2 bubbles), 5 instructions.
        for (int i = 0; i < 6; i++) tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0040;
        tick();
        bus.redirect = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (perf_fetched !== 32'd10) begin errors++; $display("FAIL perf_fetched got %0d exp 10", perf_fetched); end
        checks++; if (perf_flushed !== 32'd3) begin errors++; $display("FAIL perf_flushed got %0d exp 3", perf_flushed); end
        force dut.perf_fetched_r = 32'hFFFF_FFFF;
        #1;
        release dut.perf_fetched_r;
        tick();
        checks++; if (perf_fetched !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_sat got %h exp FFFFFFFF", perf_fetched); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
        mem[0] = 16'h8101;
        mem[1] = 16'h8202;
        mem[2] = 16'h8303;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_halt();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
